// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner for packed BCD digits.
// A load request captures a digit snapshot. The snapshot is applied only at a
// frame boundary, so a refresh never shows a half-updated value. The applied
// digits are then time-multiplexed onto one shared, active-low segment bus.
// The scanner also provides leading-zero blanking and a sticky invalid-code
// flag.
module bcd_display_scan #(
    parameter int N_DIGITS    = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digit_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  load_ack,
    output logic                  frame_done,
    output logic                  err
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Scan timing state
    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      idx;
    logic                  started;

    // Snapshot state: the held request and the digits currently on display
    logic                  pending;
    logic [4*N_DIGITS-1:0] sample_digits;
    logic [N_DIGITS-1:0]   sample_dp;
    logic [4*N_DIGITS-1:0] shadow_digits;
    logic [N_DIGITS-1:0]   shadow_dp;

    // Combinational helpers for the next display update
    logic                  tick;
    logic [IDX_W-1:0]      next_idx;
    logic                  boundary;
    logic                  apply;
    logic [4*N_DIGITS-1:0] new_digits;
    logic [N_DIGITS-1:0]   new_dp;
    logic [4*N_DIGITS-1:0] eff_digits;
    logic [N_DIGITS-1:0]   eff_dp;
    logic                  new_invalid;
    logic                  zero_run;
    logic [N_DIGITS-1:0]   lz_mask;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [N_DIGITS-1:0]   an_onehot;

    // Active-low segment pattern {g,f,e,d,c,b,a}; codes above 9 show a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    // Tick, next slot, and whether this update applies a pending or bypassed snapshot
    always_comb begin
        tick       = (prescaler == PRE_LAST);
        next_idx   = '0;
        if (started && (idx != IDX_LAST)) begin
            next_idx = idx + IDX_W'(1);
        end
        boundary   = tick && (next_idx == '0);
        apply      = boundary && (pending || load);
        new_digits = load ? digit_in : sample_digits;
        new_dp     = load ? dp_in    : sample_dp;
        eff_digits = apply ? new_digits : shadow_digits;
        eff_dp     = apply ? new_dp     : shadow_dp;
    end

    // Flag any nibble of the snapshot being applied that is not a BCD digit
    always_comb begin
        new_invalid = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (new_digits[4*k +: 4] > 4'd9) begin
                new_invalid = 1'b1;
            end
        end
    end

    // Mark digits that are zero together with every more significant digit
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (eff_digits[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_run;
        end
    end

    // Select the code, decimal point, blank status and anode for the next slot
    always_comb begin
        cur_code  = 4'd0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (next_idx == IDX_W'(k)) begin
                cur_code     = eff_digits[4*k +: 4];
                cur_dp       = eff_dp[k];
                cur_lz       = lz_mask[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

    // Free-running refresh prescaler, one tick every REFRESH_DIV cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Advance the lit digit on each tick; the first tick after reset always starts at digit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            started <= 1'b0;
        end else if (tick) begin
            idx     <= next_idx;
            started <= 1'b1;
        end
    end

    // Hold the latest load request and move it into the shadow at a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= 1'b0;
            sample_digits <= '0;
            sample_dp     <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            err           <= 1'b0;
        end else if (apply) begin
            pending       <= 1'b0;
            shadow_digits <= new_digits;
            shadow_dp     <= new_dp;
            err           <= new_invalid;
        end else if (load) begin
            pending       <= 1'b1;
            sample_digits <= digit_in;
            sample_dp     <= dp_in;
        end
    end

    // Registered display outputs, refreshed only on a tick, plus the status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= apply;
            frame_done <= boundary;
            if (tick) begin
                if (blank_lz && cur_lz) begin
                    seg_n <= 7'h7F;
                    dp_n  <= 1'b1;
                    an_n  <= '1;
                end else begin
                    seg_n <= seg_decode(cur_code);
                    dp_n  <= ~cur_dp;
                    an_n  <= ~an_onehot;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (REFRESH_DIV=4, N_DIGITS=2).
// The reference model counts clock edges since reset. From that count it
// derives the refresh slot and the lit digit with plain arithmetic.
module tb_bcd_display_scan;

    localparam int DIV = 4;
    localparam int ND  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    digit_in = 8'h00;
    logic [1:0]    dp_in = 2'b00;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [1:0]    an_n;
    logic          load_ack;
    logic          frame_done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_cycle;
    int         m_dig[ND];
    logic [1:0] m_dpv;
    logic       m_pending;
    logic [7:0] m_sample;
    logic [1:0] m_sample_dp;
    logic       m_err;
    logic [6:0] m_seg;
    logic       m_dpn;
    logic [1:0] m_an;
    logic       m_ack;
    logic       m_fd;
    logic [6:0] seg_table[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_display_scan #(.N_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n),
        .an_n(an_n), .load_ack(load_ack), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cycle = 0;
        for (int j = 0; j < ND; j++) m_dig[j] = 0;
        m_dpv = '0; m_pending = 1'b0; m_sample = '0; m_sample_dp = '0; m_err = 1'b0;
        m_seg = 7'h7F; m_dpn = 1'b1; m_an = 2'b11; m_ack = 1'b0; m_fd = 1'b0;
    endtask

    // One clock edge: capture the inputs, advance the DUT and the model, then return at the falling edge
    task automatic cycle();
        logic       ld, blz, tick, bnd, blanked;
        logic [7:0] din;
        logic [1:0] dpi;
        int         disp;
        ld = load; din = digit_in; dpi = dp_in; blz = blank_lz;
        @(posedge clk);
        m_cycle++;
        tick = (m_cycle % DIV == 0);
        disp = tick ? ((m_cycle / DIV - 1) % ND) : 0;
        bnd  = tick && (disp == 0);
        m_ack = 1'b0;
        m_fd  = bnd;
        if (bnd && (ld || m_pending)) begin
            if (!ld) begin din = m_sample; dpi = m_sample_dp; end
            m_dig[0] = int'(din[3:0]);
            m_dig[1] = int'(din[7:4]);
            m_dpv = dpi;
            m_pending = 1'b0;
            m_ack = 1'b1;
            m_err = (m_dig[0] > 9) || (m_dig[1] > 9);
        end else if (ld) begin
            m_pending = 1'b1; m_sample = din; m_sample_dp = dpi;
        end
        if (tick) begin
            blanked = blz && (disp >= 1);
            for (int j = disp; j < ND; j++) if (m_dig[j] != 0) blanked = 1'b0;
            if (blanked) begin
                m_seg = 7'h7F; m_dpn = 1'b1; m_an = 2'b11;
            end else begin
                m_seg = (m_dig[disp] > 9) ? 7'h3F : seg_table[m_dig[disp]];
                m_dpn = ~m_dpv[disp];
                m_an  = ~(2'b01 << disp);
            end
        end
        @(negedge clk);
    endtask

    // Step until the next edge is a tick that lights digit d
    task automatic advance_to(input int d);
        int guard = 0;
        while (!(((m_cycle + 1) % DIV == 0) && ((((m_cycle + 1) / DIV) - 1) % ND == d)) && guard < 20) begin
            cycle();
            guard++;
        end
        if (guard >= 20) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL advance_to: no slot for digit %0d within 20 cycles", d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++; if (seg_n !== 7'h7F) begin n_fail++; $display("[TB] FAIL reset_seg: got %h expected 7f", seg_n); end
        n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_dp: got %b expected 1", dp_n); end
        n_checks++; if (an_n !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_an: got %b expected 11", an_n); end
        n_checks++; if ({load_ack, frame_done, err} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {load_ack, frame_done, err}); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_default_frame();
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c < 4) begin
                n_checks++; if ({seg_n, an_n, frame_done} !== {7'h7F, 2'b11, 1'b0}) begin n_fail++; $display("[TB] FAIL frame_hold c%0d: got %h/%b/%b expected 7f/11/0", c, seg_n, an_n, frame_done); end
            end
            if (c == 4 || c == 12) begin
                n_checks++; if ({seg_n, an_n, frame_done} !== {7'h40, 2'b10, 1'b1}) begin n_fail++; $display("[TB] FAIL frame_d0 c%0d: got %h/%b/%b expected 40/10/1", c, seg_n, an_n, frame_done); end
            end
            if (c == 8) begin
                n_checks++; if ({seg_n, an_n, frame_done} !== {7'h40, 2'b01, 1'b0}) begin n_fail++; $display("[TB] FAIL frame_d1 c%0d: got %h/%b/%b expected 40/01/0", c, seg_n, an_n, frame_done); end
            end
        end
    endtask

    task automatic test_snapshot_timing();
        advance_to(1); cycle();
        load = 1'b1; digit_in = 8'h47; cycle(); load = 1'b0;
        n_checks++; if ({load_ack, seg_n, an_n} !== {1'b0, 7'h40, 2'b01}) begin n_fail++; $display("[TB] FAIL snap_hold: got %b/%h/%b expected 0/40/01", load_ack, seg_n, an_n); end
        advance_to(0); cycle();
        n_checks++; if ({load_ack, seg_n, an_n} !== {1'b1, 7'h78, 2'b10}) begin n_fail++; $display("[TB] FAIL snap_apply: got %b/%h/%b expected 1/78/10", load_ack, seg_n, an_n); end
        cycle();
        n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL snap_ack_pulse: got %b expected 0", load_ack); end
        advance_to(1); cycle();
        n_checks++; if ({seg_n, an_n} !== {7'h19, 2'b01}) begin n_fail++; $display("[TB] FAIL snap_d1: got %h/%b expected 19/01", seg_n, an_n); end
    endtask

    task automatic test_same_cycle_load();
        advance_to(0);
        load = 1'b1; digit_in = 8'h25; cycle(); load = 1'b0;
        n_checks++; if ({load_ack, frame_done, seg_n, an_n} !== {1'b1, 1'b1, 7'h12, 2'b10}) begin n_fail++; $display("[TB] FAIL same_cycle: got %b/%b/%h/%b expected 1/1/12/10", load_ack, frame_done, seg_n, an_n); end
    endtask

    task automatic test_blanking();
        blank_lz = 1'b1;
        advance_to(0);
        load = 1'b1; digit_in = 8'h05; cycle(); load = 1'b0;
        n_checks++; if (seg_n !== 7'h12) begin n_fail++; $display("[TB] FAIL blank_d0: got %h expected 12", seg_n); end
        advance_to(1); cycle();
        n_checks++; if ({seg_n, dp_n, an_n} !== {7'h7F, 1'b1, 2'b11}) begin n_fail++; $display("[TB] FAIL blank_on: got %h/%b/%b expected 7f/1/11", seg_n, dp_n, an_n); end
        blank_lz = 1'b0;
        advance_to(1); cycle();
        n_checks++; if ({seg_n, an_n} !== {7'h40, 2'b01}) begin n_fail++; $display("[TB] FAIL blank_off: got %h/%b expected 40/01", seg_n, an_n); end
    endtask

    task automatic test_invalid_code();
        advance_to(0);
        load = 1'b1; digit_in = 8'hA3; cycle(); load = 1'b0;
        n_checks++; if ({err, seg_n} !== {1'b1, 7'h30}) begin n_fail++; $display("[TB] FAIL inval_apply: got %b/%h expected 1/30", err, seg_n); end
        advance_to(1); cycle();
        n_checks++; if ({seg_n, an_n} !== {7'h3F, 2'b01}) begin n_fail++; $display("[TB] FAIL inval_dash: got %h/%b expected 3f/01", seg_n, an_n); end
        load = 1'b1; digit_in = 8'h12; cycle(); load = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL inval_sticky: got %b expected 1", err); end
        advance_to(0); cycle();
        n_checks++; if ({err, load_ack, seg_n} !== {1'b0, 1'b1, 7'h24}) begin n_fail++; $display("[TB] FAIL inval_clear: got %b/%b/%h expected 0/1/24", err, load_ack, seg_n); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            load = ($urandom_range(0, 5) == 0);
            digit_in = ($urandom_range(0, 2) == 0) ? {4'd0, 4'($urandom_range(0, 15))} : 8'($urandom);
            dp_in = 2'($urandom);
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            cycle();
            n_checks++; if (seg_n !== m_seg) begin n_fail++; $display("[TB] FAIL rand_seg c%0d: got %h expected %h", m_cycle, seg_n, m_seg); end
            n_checks++; if (dp_n !== m_dpn) begin n_fail++; $display("[TB] FAIL rand_dp c%0d: got %b expected %b", m_cycle, dp_n, m_dpn); end
            n_checks++; if (an_n !== m_an) begin n_fail++; $display("[TB] FAIL rand_an c%0d: got %b expected %b", m_cycle, an_n, m_an); end
            n_checks++; if (load_ack !== m_ack) begin n_fail++; $display("[TB] FAIL rand_ack c%0d: got %b expected %b", m_cycle, load_ack, m_ack); end
            n_checks++; if (frame_done !== m_fd) begin n_fail++; $display("[TB] FAIL rand_fd c%0d: got %b expected %b", m_cycle, frame_done, m_fd); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("[TB] FAIL rand_err c%0d: got %b expected %b", m_cycle, err, m_err); end
        end
        load = 1'b0; blank_lz = 1'b0; dp_in = 2'b00;
    endtask

    task automatic test_reset_mid();
        advance_to(0);
        load = 1'b1; digit_in = 8'h9A; cycle(); load = 1'b0;
        n_checks++; if ({err, seg_n} !== {1'b1, 7'h3F}) begin n_fail++; $display("[TB] FAIL rmid_setup: got %b/%h expected 1/3f", err, seg_n); end
        advance_to(1); cycle();
        n_checks++; if (seg_n !== 7'h10) begin n_fail++; $display("[TB] FAIL rmid_d1: got %h expected 10", seg_n); end
        load = 1'b1; digit_in = 8'h47; cycle(); load = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({seg_n, dp_n, an_n, err} !== {7'h7F, 1'b1, 2'b11, 1'b0}) begin n_fail++; $display("[TB] FAIL rmid_async: got %h/%b/%b/%b expected 7f/1/11/0", seg_n, dp_n, an_n, err); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 1; c <= 12; c++) begin
            cycle();
            n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_no_ack c%0d: got %b expected 0", c, load_ack); end
            if (c == 4 || c == 8) begin
                n_checks++; if ({seg_n, an_n} !== {7'h40, (c == 4) ? 2'b10 : 2'b01}) begin n_fail++; $display("[TB] FAIL rmid_shadow c%0d: got %h/%b expected 40", c, seg_n, an_n); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_frame();
        test_snapshot_timing();
        test_same_cycle_load();
        test_blanking();
        test_invalid_code();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Multiplexed 7-segment scanner for packed BCD digits, e.g. the q0/q1 outputs of the decade-counter chain.
- Captures a digit snapshot on request, applies it only at a frame boundary so a refresh never shows a torn value, then time-multiplexes the digits onto one shared segment bus.
- Supports leading-zero blanking and flags invalid BCD codes.
- Sits between the counter logic and the board display pins.

Parameters:
- N_DIGITS, 2, number of multiplexed digits (1..8); digit 0 is least significant.
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset. Clock is clk.
- digit_in  in  4*N_DIGITS  packed BCD; digit k = bits [4k+3:4k].
- dp_in  in  N_DIGITS  decimal-point request per digit, active-high.
- load  in  1  snapshot request; samples digit_in/dp_in this cycle.
- blank_lz  in  1  leading-zero suppression enable; sampled live.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp_n  out  1  decimal point, active-low, registered.
- an_n  out  N_DIGITS  digit anodes, active-low one-hot or all-high, registered.
- load_ack  out  1  1-cycle pulse when a pending snapshot is applied.
- frame_done  out  1  1-cycle pulse on each frame-boundary tick.
- err  out  1  sticky flag: the applied snapshot contains a code greater than 9.

Behaviour:
- Reset values:
  - prescaler=0, idx=0, started=0.
  - shadow digits=0, shadow dp=0, pending=0, held sample=0.
  - seg_n=7'h7F, dp_n=1, an_n=all 1s.
  - load_ack=0, frame_done=0, err=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler==REFRESH_DIV-1).
  - First tick occurs REFRESH_DIV cycles after reset deassertion.
- Scan: on tick, next index = started ? (idx==N_DIGITS-1 ? 0 : idx+1) : 0. Then started<=1, idx<=next index.
- Output registers are updated only on tick, from the next index. Outputs hold between ticks.
- A frame boundary is a tick whose next index is 0. frame_done pulses in that tick's update cycle.
- Snapshot:
  - load=1 sets pending=1 and stores digit_in/dp_in into a held sample.
  - A later load before application overwrites the held sample; the last request wins.
- At a frame boundary with pending=1 (including a load in the same cycle, which is bypassed directly):
  - shadow<=sample, pending<=0, load_ack pulses.
  - The digit-0 output in that same update uses the new shadow value.
- err:
  - Recomputed at each application: 1 if any shadow digit > 9, else 0.
  - Holds between applications; cleared only by reset or by a later all-valid application.
- Decode, seg_n hex for 0..9: 40,79,24,30,19,12,02,78,00,10.
- An invalid code (>9) displays the dash 3F; the anode is still driven.
- Leading-zero blank:
  - When blank_lz=1, digit k>=1 is blanked if digit k and all higher shadow digits are 0.
  - Blanked means seg_n=7F, dp_n=1, an_n=all 1s for that slot.
  - Digit 0 is never blanked.
- dp_n = ~shadow_dp[idx] for non-blanked digits.
- an_n = ~(1<<idx) for non-blanked digits.
- Reset mid-frame: all state returns immediately to reset values, and any pending snapshot is discarded.

Test Plan:
- Default frame (REFRESH_DIV=4, N_DIGITS=2), no load, release reset -> outputs hold their reset values for cycles 1..3. At cycle 4: an_n=2'b10, seg_n=40, frame_done=1. At cycle 8: an_n=2'b01, seg_n=40. At cycle 12: frame_done=1 again.
- Snapshot timing: load with digit_in=8'h47 mid-frame while digit 1 is lit -> shadow is unchanged until the next boundary. At the boundary: load_ack=1, digit 0 shows 78 (7). Next tick: digit 1 shows 19 (4).
- Same-cycle load: load with 8'h25 asserted exactly on a boundary tick -> applied in that update; digit 0 shows 12 (5) and load_ack=1.
- Blanking: load 8'h05 with blank_lz=1 -> digit 1 slot shows an_n=2'b11, seg_n=7F. With blank_lz=0 -> digit 1 shows 40, an_n=2'b01.
- Invalid code: load 8'hA3 -> after application err=1; digit 1 shows 3F, digit 0 shows 30 (3). Then load 8'h12 -> err=0 at the next application.
- Reset mid-operation: assert reset with pending=1 while digit 1 is lit -> an_n=11, seg_n=7F, err=0. After release, no load_ack occurs and shadow=0.
